// File: rtl/t05_huffman_pkg.sv
// Shared types and default sizing for the Huffman stream decoder.
package t05_huffman_pkg;
  localparam int SYM_W_DEF        = 8;
  localparam int NUM_SYMS_DEF     = 256;
  localparam int MAX_CODE_LEN_DEF = 16;
  localparam int IN_W_DEF         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LK_REQ,
    ST_LK_CHK,
    ST_EMIT,
    ST_DONE,
    ST_ERROR
  } huff_state_t;
endpackage

// File: rtl/t05_huffman_bitbuf.sv
// MSB-aligned bit buffer: input words append below the valid bits, matched
// codes are consumed from the top by a left shift.
module t05_huffman_bitbuf
  import t05_huffman_pkg::*;
#(
  parameter int  MAX_CODE_LEN = MAX_CODE_LEN_DEF,
  parameter int  IN_W         = IN_W_DEF,
  localparam int BUF_W        = MAX_CODE_LEN + IN_W,
  localparam int CNT_W        = $clog2(BUF_W + 1),
  localparam int LEN_W        = $clog2(MAX_CODE_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             append,
  input  logic [IN_W-1:0]  append_data,
  input  logic             consume,
  input  logic [LEN_W-1:0] consume_len,
  output logic [BUF_W-1:0] bit_buf,
  output logic [CNT_W-1:0] bit_cnt
);
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bits below the valid region are always zero, so appending is a plain OR.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (append) begin
      buf_d = buf_q | ({append_data, {MAX_CODE_LEN{1'b0}}} >> cnt_q);
      cnt_d = cnt_q + CNT_W'(IN_W);
    end else if (consume) begin
      buf_d = buf_q << consume_len;
      cnt_d = cnt_q - CNT_W'(consume_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_buf = buf_q;
  assign bit_cnt = cnt_q;
endmodule

// File: rtl/t05_huffman_stream_decode.sv
// Huffman stream decoder: linear codebook search per symbol, matching each
// entry on its true code length against the head of the bit buffer.
module t05_huffman_stream_decode
  import t05_huffman_pkg::*;
#(
  parameter int  SYM_W        = SYM_W_DEF,
  parameter int  NUM_SYMS     = NUM_SYMS_DEF,
  parameter int  MAX_CODE_LEN = MAX_CODE_LEN_DEF,
  parameter int  IN_W         = IN_W_DEF,
  localparam int ADDR_W       = $clog2(NUM_SYMS),
  localparam int LEN_W        = $clog2(MAX_CODE_LEN + 1),
  localparam int BUF_W        = MAX_CODE_LEN + IN_W,
  localparam int CNT_W        = $clog2(BUF_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             tot_syms,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    cb_rd_en,
  output logic [ADDR_W-1:0]       cb_addr,
  input  logic [MAX_CODE_LEN-1:0] cb_code,
  input  logic [LEN_W-1:0]        cb_len,
  output logic [SYM_W-1:0]        sym_data,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             syms_found
);
  huff_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       tot_q, tot_d, found_q, found_d;
  logic              last_q, last_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [LEN_W-1:0]  mlen_q, mlen_d;

  logic                    buf_clr, buf_app, buf_cons;
  logic [BUF_W-1:0]        bit_buf;
  logic [CNT_W-1:0]        bit_cnt;
  logic [MAX_CODE_LEN-1:0] head, len_mask;
  logic                    match;

  t05_huffman_bitbuf #(.MAX_CODE_LEN(MAX_CODE_LEN), .IN_W(IN_W)) u_bitbuf (
    .clk         (clk),
    .rst         (rst),
    .clr         (buf_clr),
    .append      (buf_app),
    .append_data (in_data),
    .consume     (buf_cons),
    .consume_len (mlen_q),
    .bit_buf     (bit_buf),
    .bit_cnt     (bit_cnt)
  );

  // Compare only the top cb_len bits; the mask keeps that many MSBs.
  assign head     = bit_buf[BUF_W-1 -: MAX_CODE_LEN];
  assign len_mask = ~({MAX_CODE_LEN{1'b1}} >> cb_len);
  assign match    = (cb_len != '0) && (32'(cb_len) <= 32'(bit_cnt)) &&
                    (((head ^ cb_code) & len_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tot_q   <= '0;
      found_q <= '0;
      last_q  <= 1'b0;
      sym_q   <= '0;
      mlen_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tot_q   <= tot_d;
      found_q <= found_d;
      last_q  <= last_d;
      sym_q   <= sym_d;
      mlen_q  <= mlen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tot_d    = tot_q;
    found_d  = found_q;
    last_d   = last_q;
    sym_d    = sym_q;
    mlen_d   = mlen_q;
    buf_clr  = 1'b0;
    buf_app  = 1'b0;
    buf_cons = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          buf_clr = 1'b1;
          found_d = '0;
          last_d  = 1'b0;
          idx_d   = '0;
          tot_d   = tot_syms;
          state_d = (tot_syms == 32'd0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_valid && in_ready) begin
          buf_app = 1'b1;
          last_d  = last_q | in_last;
        end
        // Decisions use the registered count, one cycle after any write.
        if (last_q && bit_cnt == '0) begin
          state_d = ST_ERROR;
        end else if (32'(bit_cnt) >= MAX_CODE_LEN || (last_q && bit_cnt != '0)) begin
          idx_d   = '0;
          state_d = ST_LK_REQ;
        end
      end
      ST_LK_REQ: state_d = ST_LK_CHK;
      ST_LK_CHK: begin
        if (match) begin
          sym_d   = SYM_W'(idx_q);
          mlen_d  = cb_len;
          state_d = ST_EMIT;
        end else if (idx_q == ADDR_W'(NUM_SYMS - 1)) begin
          state_d = ST_ERROR;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_LK_REQ;
        end
      end
      ST_EMIT: begin
        if (sym_ready) begin
          buf_cons = 1'b1;
          found_d  = found_q + 32'd1;
          state_d  = (found_d == tot_q) ? ST_DONE : ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_FILL) && (32'(bit_cnt) <= MAX_CODE_LEN) && !last_q;
    cb_rd_en  = (state_q == ST_LK_REQ);
    sym_valid = (state_q == ST_EMIT);
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_ERROR);
    busy      = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  end

  assign cb_addr    = idx_q;
  assign sym_data   = sym_q;
  assign syms_found = found_q;
endmodule

// File: tb/tb_t05_huffman_stream_decode.sv
// Directed bench for the Huffman stream decoder with a registered codebook SRAM model.
module tb_t05_huffman_stream_decode;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, sym_ready;
  logic [31:0] tot_syms;
  logic [7:0]  in_data;
  logic        in_ready, cb_rd_en, sym_valid, busy, done, err;
  logic [7:0]  cb_addr, sym_data;
  logic [15:0] cb_code;
  logic [4:0]  cb_len;
  logic [31:0] syms_found;

  logic [15:0] code_mem [256];
  logic [4:0]  len_mem  [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  t05_huffman_stream_decode dut (
    .clk(clk), .rst(rst), .start(start), .tot_syms(tot_syms),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cb_rd_en(cb_rd_en), .cb_addr(cb_addr), .cb_code(cb_code), .cb_len(cb_len),
    .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .busy(busy), .done(done), .err(err), .syms_found(syms_found)
  );

  always @(posedge clk) begin
    if (cb_rd_en) begin
      cb_code <= code_mem[cb_addr];
      cb_len  <= len_mem[cb_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cb_clear();
    for (int i = 0; i < 256; i++) begin
      code_mem[i] = '0;
      len_mem[i]  = '0;
    end
  endtask

  task automatic cb_abc();
    cb_clear();
    code_mem[8'h41] = 16'h0000; len_mem[8'h41] = 5'd1;
    code_mem[8'h42] = 16'h8000; len_mem[8'h42] = 5'd2;
    code_mem[8'h43] = 16'hC000; len_mem[8'h43] = 5'd2;
  endtask

  task automatic go(input logic [31:0] n);
    tot_syms = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input logic last);
    int n = 0;
    in_data = b; in_valid = 1'b1; in_last = last;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_wait", 32'(n < 50), 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // exp holds expected symbols, first symbol in the low byte.
  task automatic collect(input int n, input logic [63:0] exp, input bit bp);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!sym_valid && w < 2000) begin tick(); w++; end
      chk("sym_wait", 32'(w < 2000), 1);
      chk("sym_data", 32'(sym_data), 32'(exp[i*8 +: 8]));
      if (bp) begin
        repeat (10) begin
          tick();
          chk("bp_valid", 32'(sym_valid), 1);
          chk("bp_data", 32'(sym_data), 32'(exp[i*8 +: 8]));
        end
      end
      sym_ready = 1'b1;
      tick();
      sym_ready = 1'b0;
    end
  endtask

  task automatic wait_end(input bit want_err);
    int n = 0;
    while (!(want_err ? err : done) && n < 2000) begin tick(); n++; end
    chk("end_wait", 32'(n < 2000), 1);
  endtask

  task automatic chk_idle();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_err", 32'(err), 0);
    chk("idle_in_ready", 32'(in_ready), 0);
    chk("idle_sym_valid", 32'(sym_valid), 0);
    chk("idle_sym_data", 32'(sym_data), 0);
    chk("idle_cb_rd_en", 32'(cb_rd_en), 0);
    chk("idle_cb_addr", 32'(cb_addr), 0);
    chk("idle_syms_found", syms_found, 0);
  endtask

  initial begin
    int  k;
    bit  seen;
    rst = 1'b1; start = 1'b0; tot_syms = '0; in_data = '0;
    in_valid = 1'b0; in_last = 1'b0; sym_ready = 1'b0;
    cb_clear();
    repeat (3) tick();
    chk_idle();
    rst = 1'b0;
    tick();

    // 0x5A = 0|10|11|0|10 -> A B C A B
    cb_abc();
    go(5);
    chk("busy_after_start", 32'(busy), 1);
    feed(8'h5A, 1'b1);
    collect(5, 64'h42_41_43_42_41, 1'b0);
    wait_end(1'b0);
    chk("basic_done", 32'(done), 1);
    chk("basic_err", 32'(err), 0);
    chk("basic_found", syms_found, 5);

    go(5);
    feed(8'h5A, 1'b1);
    collect(5, 64'h42_41_43_42_41, 1'b1);
    wait_end(1'b0);
    chk("bp_done", 32'(done), 1);
    chk("bp_found", syms_found, 5);

    cb_clear();
    code_mem[7] = 16'hA5C3; len_mem[7] = 5'd16;
    go(1);
    feed(8'hA5, 1'b0);
    feed(8'hC3, 1'b1);
    collect(1, 64'h07, 1'b0);
    wait_end(1'b0);
    chk("long_done", 32'(done), 1);
    chk("long_found", syms_found, 1);

    // Full 256-entry miss at 2 cycles per entry.
    cb_clear();
    len_mem[8'h41] = 5'd1;
    go(1);
    feed(8'hFF, 1'b1);
    k = 0;
    while (!(cb_rd_en && cb_addr == 8'd0) && k < 20) begin tick(); k++; end
    chk("nomatch_first_req", 32'(k < 20), 1);
    k = 0; seen = 1'b0;
    while (!err && k < 600) begin
      tick(); k++;
      if (sym_valid) seen = 1'b1;
    end
    chk("nomatch_latency", 32'(k), 512);
    chk("nomatch_no_sym", 32'(seen), 0);
    chk("nomatch_done", 32'(done), 0);

    go(0);
    chk("zero_done", 32'(done), 1);
    seen = 1'b0;
    repeat (5) begin
      if (in_ready || cb_rd_en || busy) seen = 1'b1;
      tick();
    end
    chk("zero_quiet", 32'(seen), 0);
    chk("zero_done_held", 32'(done), 1);

    // Reset while the first lookup is being checked.
    cb_abc();
    go(5);
    feed(8'h5A, 1'b1);
    k = 0;
    while (!cb_rd_en && k < 20) begin tick(); k++; end
    chk("rst_reach_req", 32'(k < 20), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle();

    go(9);
    feed(8'h5A, 1'b1);
    collect(5, 64'h42_41_43_42_41, 1'b0);
    wait_end(1'b1);
    chk("exhaust_err", 32'(err), 1);
    chk("exhaust_done", 32'(done), 0);
    chk("exhaust_found", syms_found, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
